node_integrator: RTL and testbench

Per-node time-step stage directly downstream of the spring force computation. Holds position and velocity state for NUM_NODES point masses. Consumes one accumulated force vector per node, in index order, once per physics step. Applies a semi-implicit Euler update and streams the new positions to rendering/collision logic.

---
 rtl/node_integrator.sv | 241 ++++++++++++++++++++++++
 tb/tb_node_integrator.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/node_integrator.sv
// ---------------------------------------------------------------------------
// node_integrator
//
// Per-node time-step stage that sits after the spring force computation.
// Holds position and velocity for NUM_NODES point masses. On each physics
// step it consumes one force vector per node, in index order. Each node gets
// a semi-implicit Euler update: the velocity is updated first, and the new
// velocity then moves the position. The new positions are streamed out to
// rendering/collision logic.
//
// Optional feature: define FLOOR_EN to clamp pos_y at FLOOR_Y. When the clamp
// fires, vel_y is replaced by the negated half velocity (an inelastic
// bounce). With FLOOR_EN undefined there is no floor logic and FLOOR_Y is
// unused.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   init_valid_in/idx/pos/vel
//                           initial-state write for one node (IDLE only)
//   step_in                 start one physics step (IDLE only)
//   force_valid_in/ready_out/force_x_in/force_y_in
//                           per-node force handshake, node 0 first
//   pos_valid_out/idx/x/y   one-cycle strobe carrying the updated position;
//                           the data outputs hold until the next strobe
//   busy_out                step in progress
//   done_out                one-cycle pulse when a step completes
// ---------------------------------------------------------------------------
module node_integrator #(
    parameter int NUM_NODES     = 4,
    parameter int POSITION_SIZE = 16,
    parameter int VELOCITY_SIZE = 16,
    parameter int FORCE_SIZE    = 16,
    parameter int DT_SHIFT      = 4,
    parameter int MASS_SHIFT    = 0,
    parameter int FLOOR_Y       = 0,
    localparam int IDX_W        = $clog2(NUM_NODES)
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            init_valid_in,
    input  logic        [IDX_W-1:0]         init_idx_in,
    input  logic signed [POSITION_SIZE-1:0] init_pos_x_in,
    input  logic signed [POSITION_SIZE-1:0] init_pos_y_in,
    input  logic signed [VELOCITY_SIZE-1:0] init_vel_x_in,
    input  logic signed [VELOCITY_SIZE-1:0] init_vel_y_in,
    input  logic                            step_in,
    input  logic                            force_valid_in,
    output logic                            force_ready_out,
    input  logic signed [FORCE_SIZE-1:0]    force_x_in,
    input  logic signed [FORCE_SIZE-1:0]    force_y_in,
    output logic                            pos_valid_out,
    output logic        [IDX_W-1:0]         pos_idx_out,
    output logic signed [POSITION_SIZE-1:0] pos_x_out,
    output logic signed [POSITION_SIZE-1:0] pos_y_out,
    output logic                            busy_out,
    output logic                            done_out
);

    // Each sum carries one guard bit above the wider operand, so the raw sum
    // never wraps before it is saturated.
    localparam int VS_W        = ((VELOCITY_SIZE > FORCE_SIZE) ? VELOCITY_SIZE : FORCE_SIZE) + 1;
    localparam int PS_W        = ((POSITION_SIZE > VELOCITY_SIZE) ? POSITION_SIZE : VELOCITY_SIZE) + 1;
    // Dividing force by mass and multiplying by dt are both power-of-two
    // operations, so they combine into a single arithmetic shift.
    localparam int FORCE_SHIFT = DT_SHIFT + MASS_SHIFT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FORCE,
        S_UPDATE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t                          state;
    logic        [IDX_W-1:0]         idx;
    logic signed [FORCE_SIZE-1:0]    force_x_q;
    logic signed [FORCE_SIZE-1:0]    force_y_q;

    logic signed [POSITION_SIZE-1:0] pos_x_mem [NUM_NODES];
    logic signed [POSITION_SIZE-1:0] pos_y_mem [NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] vel_x_mem [NUM_NODES];
    logic signed [VELOCITY_SIZE-1:0] vel_y_mem [NUM_NODES];

    logic signed [VS_W-1:0]          vel_sum_x;
    logic signed [VS_W-1:0]          vel_sum_y;
    logic signed [PS_W-1:0]          pos_sum_x;
    logic signed [PS_W-1:0]          pos_sum_y;
    logic signed [VELOCITY_SIZE-1:0] new_vel_x;
    logic signed [VELOCITY_SIZE-1:0] new_vel_y;
    logic signed [POSITION_SIZE-1:0] new_pos_x;
    logic signed [POSITION_SIZE-1:0] new_pos_y;

    // A value fits the target width exactly when every bit from the target
    // sign bit upwards matches, i.e. when the shifted-down value is 0 or -1.
    function automatic logic signed [VELOCITY_SIZE-1:0] sat_vel(input logic signed [VS_W-1:0] s);
        logic signed [VS_W-1:0] hi;
        hi = s >>> (VELOCITY_SIZE - 1);
        if (hi == '0 || hi == '1)
            sat_vel = s[VELOCITY_SIZE-1:0];
        else if (s[VS_W-1])
            sat_vel = {1'b1, {(VELOCITY_SIZE-1){1'b0}}};
        else
            sat_vel = {1'b0, {(VELOCITY_SIZE-1){1'b1}}};
    endfunction

    function automatic logic signed [POSITION_SIZE-1:0] sat_pos(input logic signed [PS_W-1:0] s);
        logic signed [PS_W-1:0] hi;
        hi = s >>> (POSITION_SIZE - 1);
        if (hi == '0 || hi == '1)
            sat_pos = s[POSITION_SIZE-1:0];
        else if (s[PS_W-1])
            sat_pos = {1'b1, {(POSITION_SIZE-1){1'b0}}};
        else
            sat_pos = {1'b0, {(POSITION_SIZE-1){1'b1}}};
    endfunction

`ifdef FLOOR_EN
    localparam logic signed [POSITION_SIZE-1:0] FLOOR_POS = POSITION_SIZE'(FLOOR_Y);
    logic signed [VS_W-1:0] bounce_vel;
`endif

    // Update datapath for the node at idx. The result is only meaningful, and
    // only written back, in S_UPDATE.
    // NOTE: every always_comb output is assigned unconditionally at the top.
    // Any later conditional override then leaves no path that holds an old
    // value, so no latch can be inferred.
    always_comb begin
        vel_sum_x = VS_W'(vel_x_mem[idx]) + VS_W'(force_x_q >>> FORCE_SHIFT);
        vel_sum_y = VS_W'(vel_y_mem[idx]) + VS_W'(force_y_q >>> FORCE_SHIFT);
        new_vel_x = sat_vel(vel_sum_x);
        new_vel_y = sat_vel(vel_sum_y);
        // Semi-implicit: the position advances with the already-updated velocity.
        pos_sum_x = PS_W'(pos_x_mem[idx]) + PS_W'(new_vel_x >>> DT_SHIFT);
        pos_sum_y = PS_W'(pos_y_mem[idx]) + PS_W'(new_vel_y >>> DT_SHIFT);
        new_pos_x = sat_pos(pos_sum_x);
        new_pos_y = sat_pos(pos_sum_y);
`ifdef FLOOR_EN
        bounce_vel = -(VS_W'(new_vel_y >>> 1));
        if (new_pos_y < FLOOR_POS) begin
            new_pos_y = FLOOR_POS;
            new_vel_y = sat_vel(bounce_vel);
        end
`endif
    end

    // NOTE: all state here is sequential and uses non-blocking assignments.
    // Every register therefore sees the pre-edge values, no matter in which
    // order the statements appear.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= S_IDLE;
            idx             <= '0;
            force_x_q       <= '0;
            force_y_q       <= '0;
            force_ready_out <= 1'b0;
            pos_valid_out   <= 1'b0;
            pos_idx_out     <= '0;
            pos_x_out       <= '0;
            pos_y_out       <= '0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            // NOTE: the node state array is deliberately reset. Reset must
            // leave every mass at rest at the origin. The array is small
            // enough to live in flops rather than in a RAM macro.
            for (int i = 0; i < NUM_NODES; i++) begin
                pos_x_mem[i] <= '0;
                pos_y_mem[i] <= '0;
                vel_x_mem[i] <= '0;
                vel_y_mem[i] <= '0;
            end
        end else begin
            // Strobes default low and are raised only for their one cycle.
            pos_valid_out <= 1'b0;
            done_out      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (init_valid_in && int'(init_idx_in) < NUM_NODES) begin
                        pos_x_mem[init_idx_in] <= init_pos_x_in;
                        pos_y_mem[init_idx_in] <= init_pos_y_in;
                        vel_x_mem[init_idx_in] <= init_vel_x_in;
                        vel_y_mem[init_idx_in] <= init_vel_y_in;
                    end
                    // A same-cycle init write has landed before node 0 is read
                    // in S_UPDATE, so node 0 sees the freshly written value.
                    if (step_in) begin
                        state           <= S_WAIT_FORCE;
                        idx             <= '0;
                        force_ready_out <= 1'b1;
                        busy_out        <= 1'b1;
                    end
                end

                S_WAIT_FORCE: begin
                    if (force_valid_in) begin
                        force_x_q       <= force_x_in;
                        force_y_q       <= force_y_in;
                        force_ready_out <= 1'b0;
                        state           <= S_UPDATE;
                    end
                end

                S_UPDATE: begin
                    pos_x_mem[idx] <= new_pos_x;
                    pos_y_mem[idx] <= new_pos_y;
                    vel_x_mem[idx] <= new_vel_x;
                    vel_y_mem[idx] <= new_vel_y;
                    pos_idx_out    <= idx;
                    pos_x_out      <= new_pos_x;
                    pos_y_out      <= new_pos_y;
                    pos_valid_out  <= 1'b1;
                    state          <= S_OUTPUT;
                end

                S_OUTPUT: begin
                    if (idx == IDX_W'(NUM_NODES - 1)) begin
                        done_out <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        idx             <= idx + 1'b1;
                        force_ready_out <= 1'b1;
                        state           <= S_WAIT_FORCE;
                    end
                end

                S_DONE: begin
                    busy_out <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    force_ready_out <= 1'b0;
                    busy_out        <= 1'b0;
                    state           <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_node_integrator.sv
// ---------------------------------------------------------------------------
// tb_node_integrator
//
// Self-checking bench for node_integrator. A behavioural model keeps each
// node's position and velocity as plain integers. It applies the Euler update
// with integer arithmetic and clamping. Stimulus mixes directed scenarios
// (zero force, known values, saturation, stalls, mid-step reset, ignored
// writes while busy) with randomized initial states and forces.
// ---------------------------------------------------------------------------
module tb_node_integrator;

    localparam int N       = 4;
    localparam int P       = 16;
    localparam int V       = 16;
    localparam int F       = 16;
    localparam int DT      = 4;
    localparam int MS      = 0;
    localparam int FLOOR_Y = 0;
    localparam int IW      = $clog2(N);

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic                init_valid_in;
    logic [IW-1:0]       init_idx_in;
    logic signed [P-1:0] init_pos_x_in;
    logic signed [P-1:0] init_pos_y_in;
    logic signed [V-1:0] init_vel_x_in;
    logic signed [V-1:0] init_vel_y_in;
    logic                step_in;
    logic                force_valid_in;
    logic                force_ready_out;
    logic signed [F-1:0] force_x_in;
    logic signed [F-1:0] force_y_in;
    logic                pos_valid_out;
    logic [IW-1:0]       pos_idx_out;
    logic signed [P-1:0] pos_x_out;
    logic signed [P-1:0] pos_y_out;
    logic                busy_out;
    logic                done_out;

    always #5 clk_in = ~clk_in;

    node_integrator #(
        .NUM_NODES     (N),
        .POSITION_SIZE (P),
        .VELOCITY_SIZE (V),
        .FORCE_SIZE    (F),
        .DT_SHIFT      (DT),
        .MASS_SHIFT    (MS),
        .FLOOR_Y       (FLOOR_Y)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .init_valid_in   (init_valid_in),
        .init_idx_in     (init_idx_in),
        .init_pos_x_in   (init_pos_x_in),
        .init_pos_y_in   (init_pos_y_in),
        .init_vel_x_in   (init_vel_x_in),
        .init_vel_y_in   (init_vel_y_in),
        .step_in         (step_in),
        .force_valid_in  (force_valid_in),
        .force_ready_out (force_ready_out),
        .force_x_in      (force_x_in),
        .force_y_in      (force_y_in),
        .pos_valid_out   (pos_valid_out),
        .pos_idx_out     (pos_idx_out),
        .pos_x_out       (pos_x_out),
        .pos_y_out       (pos_y_out),
        .busy_out        (busy_out),
        .done_out        (done_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference state and the force each node receives in the current step.
    int m_px [N];
    int m_py [N];
    int m_vx [N];
    int m_vy [N];
    int fx   [N];
    int fy   [N];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int rnd(input int w);
        return int'($urandom_range((1 << w) - 1, 0)) - (1 << (w - 1));
    endfunction

    // One semi-implicit Euler step for node i, using integer floor shifts.
    function automatic void model_node(input int i);
        m_vx[i] = sat(m_vx[i] + (fx[i] >>> (DT + MS)), V);
        m_vy[i] = sat(m_vy[i] + (fy[i] >>> (DT + MS)), V);
        m_px[i] = sat(m_px[i] + (m_vx[i] >>> DT), P);
        m_py[i] = sat(m_py[i] + (m_vy[i] >>> DT), P);
`ifdef FLOOR_EN
        if (m_py[i] < FLOOR_Y) begin
            m_py[i] = FLOOR_Y;
            m_vy[i] = sat(-(m_vy[i] >>> 1), V);
        end
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_px[i] = 0;
            m_py[i] = 0;
            m_vx[i] = 0;
            m_vy[i] = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, force_ready_out, 0);
        check({tag, "_pos_valid"}, pos_valid_out, 0);
        check({tag, "_busy"}, busy_out, 0);
        check({tag, "_done"}, done_out, 0);
        check({tag, "_idx"}, pos_idx_out, 0);
        check({tag, "_x"}, pos_x_out, 0);
        check({tag, "_y"}, pos_y_out, 0);
    endtask

    task automatic drive_init(input int i, input int px, input int py, input int vx, input int vy);
        init_valid_in = 1'b1;
        init_idx_in   = IW'(i);
        init_pos_x_in = P'(px);
        init_pos_y_in = P'(py);
        init_vel_x_in = V'(vx);
        init_vel_y_in = V'(vy);
    endtask

    // Writes a node in IDLE; optionally raises step_in in the same cycle.
    task automatic init_node(input int i, input int px, input int py, input int vx, input int vy,
                             input bit with_step);
        drive_init(i, px, py, vx, vy);
        step_in = with_step;
        tick();
        init_valid_in = 1'b0;
        step_in       = 1'b0;
        m_px[i] = px;
        m_py[i] = py;
        m_vx[i] = vx;
        m_vy[i] = vy;
    endtask

    task automatic start_step();
        step_in = 1'b1;
        tick();
        step_in = 1'b0;
        check("start_busy", busy_out, 1);
        check("start_ready", force_ready_out, 1);
    endtask

    // Runs one node: optional stall (with optional illegal init/step pokes),
    // force acceptance, and a position strobe exactly two cycles later.
    task automatic do_node(input int i, input int stall, input bit poke);
        for (int c = 0; c < stall; c++) begin
            if (poke) begin
                drive_init($urandom_range(N - 1, 0), rnd(P), rnd(P), rnd(V), rnd(V));
                step_in = 1'b1;
            end
            tick();
            check("stall_ready", force_ready_out, 1);
            check("stall_no_pos", pos_valid_out, 0);
            check("stall_busy", busy_out, 1);
        end
        init_valid_in = 1'b0;
        step_in       = 1'b0;
        check("pre_accept_ready", force_ready_out, 1);
        force_valid_in = 1'b1;
        force_x_in     = F'(fx[i]);
        force_y_in     = F'(fy[i]);
        tick();
        force_valid_in = 1'b0;
        force_x_in     = F'(rnd(F));
        force_y_in     = F'(rnd(F));
        check("update_ready_low", force_ready_out, 0);
        check("update_no_pos", pos_valid_out, 0);
        tick();
        model_node(i);
        check("pos_valid", pos_valid_out, 1);
        check("pos_idx", pos_idx_out, i);
        check("pos_x", pos_x_out, m_px[i]);
        check("pos_y", pos_y_out, m_py[i]);
        tick();
        check("pos_strobe_end", pos_valid_out, 0);
        check("pos_x_hold", pos_x_out, m_px[i]);
        check("pos_y_hold", pos_y_out, m_py[i]);
    endtask

    task automatic finish_step();
        check("done_pulse", done_out, 1);
        check("done_busy", busy_out, 1);
        tick();
        check("done_end", done_out, 0);
        check("idle_busy", busy_out, 0);
        check("idle_ready", force_ready_out, 0);
    endtask

    task automatic run_step(input int stall_node, input int stall, input bit poke);
        start_step();
        for (int i = 0; i < N; i++)
            do_node(i, (i == stall_node) ? stall : 0, poke);
        finish_step();
    endtask

    task automatic random_forces();
        for (int i = 0; i < N; i++) begin
            fx[i] = rnd(F);
            fy[i] = rnd(F);
        end
    endtask

    initial begin
        rst_in         = 1'b1;
        init_valid_in  = 1'b0;
        init_idx_in    = '0;
        init_pos_x_in  = '0;
        init_pos_y_in  = '0;
        init_vel_x_in  = '0;
        init_vel_y_in  = '0;
        step_in        = 1'b0;
        force_valid_in = 1'b0;
        force_x_in     = '0;
        force_y_in     = '0;
        model_reset();

        // Reset state.
        tick();
        tick();
        check_all_zero("reset");
        rst_in = 1'b0;
        tick();
        check_all_zero("post_reset");

        // Zero force on every node: positions stay at the origin.
        for (int i = 0; i < N; i++) begin
            fx[i] = 0;
            fy[i] = 0;
        end
        run_step(-1, 0, 1'b0);

        // Known values on node 0, written in the same cycle as step_in.
        random_forces();
        fx[0] = 160;
        fy[0] = -32;
        init_node(0, 100, 50, 32, -16, 1'b1);
        check("init_step_busy", busy_out, 1);
        check("init_step_ready", force_ready_out, 1);
        do_node(0, 0, 1'b0);
        check("node0_x_known", pos_x_out, 102);
        check("node0_y_known", pos_y_out, 48);
        for (int i = 1; i < N; i++)
            do_node(i, 0, 1'b0);
        finish_step();

        // Saturation on node 1: vel_x clamps, pos_x stays at maximum.
        init_node(1, 32767, 0, 32760, 0, 1'b0);
        random_forces();
        fx[1] = 32767;
        fy[1] = 0;
        start_step();
        do_node(0, 0, 1'b0);
        do_node(1, 0, 1'b0);
        check("node1_x_sat", pos_x_out, 32767);
        do_node(2, 0, 1'b0);
        do_node(3, 0, 1'b0);
        finish_step();
        random_forces();
        fx[1] = 0;
        run_step(-1, 0, 1'b0);

        // Ten-cycle stall on node 1, with init writes and step_in poked
        // while busy; a following step shows the node state was untouched.
        random_forces();
        run_step(1, 10, 1'b1);
        random_forces();
        run_step(-1, 0, 1'b0);

        // Randomized steps with random initial states and stalls.
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < 2; k++)
                init_node($urandom_range(N - 1, 0), rnd(P), rnd(P), rnd(V), rnd(V), 1'b0);
            random_forces();
            run_step($urandom_range(N - 1, 0), $urandom_range(3, 0), 1'b0);
        end

        // Reset while node 2 is in UPDATE: the step aborts with no done_out.
        random_forces();
        start_step();
        do_node(0, 0, 1'b0);
        do_node(1, 0, 1'b0);
        check("rst_pre_ready", force_ready_out, 1);
        force_valid_in = 1'b1;
        force_x_in     = F'(fx[2]);
        force_y_in     = F'(fy[2]);
        tick();
        force_valid_in = 1'b0;
        rst_in         = 1'b1;
        tick();
        rst_in = 1'b0;
        model_reset();
        check_all_zero("mid_rst");
        tick();
        check_all_zero("mid_rst_after");
        random_forces();
        run_step(-1, 0, 1'b0);

`ifdef FLOOR_EN
        // Floor bounce: pos_y would reach -1, clamps to the floor, and
        // vel_y becomes +16.
        for (int i = 0; i < N; i++) begin
            fx[i] = 0;
            fy[i] = 0;
        end
        init_node(0, 0, 1, 0, -32, 1'b0);
        start_step();
        do_node(0, 0, 1'b0);
        check("floor_y_clamp", pos_y_out, FLOOR_Y);
        for (int i = 1; i < N; i++)
            do_node(i, 0, 1'b0);
        finish_step();
        run_step(-1, 0, 1'b0);
        check("floor_bounce_y", m_py[0], 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
